// File: rtl/btb_2way_if.sv
// Lookup / update / flush bus between the fetch unit and the 2-way BTB.
interface btb_2way_if;
    logic [31:0] lookup_pc_i;
    logic        hit_o;
    logic        taken_o;
    logic [31:0] target_o;
    logic        upd_en_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        flush_i;
    logic        busy_o;

    modport master (
        output lookup_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
        input  hit_o, taken_o, target_o, busy_o
    );

    modport slave (
        input  lookup_pc_i, upd_en_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
        output hit_o, taken_o, target_o, busy_o
    );
endinterface

// File: rtl/btb_2way.sv
// Two-way set-associative branch target buffer with 2-bit direction counters,
// per-set LRU and a sequential one-set-per-cycle flush engine.
//
// state  | meaning
// IDLE   | lookups served, updates accepted
// FLUSH  | clearing valid/LRU of set cnt_q, outputs forced to miss, updates dropped
module btb_2way #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    btb_2way_if.slave    bus
);
    localparam int SETS = 2 ** INDEX_WIDTH;
    localparam int TW   = 32 - INDEX_WIDTH - 2;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] cnt_q;
    logic                   busy_q;

    logic [1:0]    valid_q [SETS];
    logic [1:0]    ctr_q   [SETS][2];
    logic [SETS-1:0] lru_q;
    logic [TW-1:0] tag_q    [SETS][2];
    logic [31:0]   target_q [SETS][2];

    // byte-offset bits never participate in indexing
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc_i[1:0], bus.upd_pc_i[1:0]};

    // lookup path: purely combinational, masked while flushing
    logic [INDEX_WIDTH-1:0] l_idx;
    logic [TW-1:0]          l_tag;
    logic                   l_m0, l_m1, l_hit;
    logic [1:0]             l_ctr;

    assign l_idx = bus.lookup_pc_i[INDEX_WIDTH+1:2];
    assign l_tag = bus.lookup_pc_i[31:INDEX_WIDTH+2];
    assign l_m0  = valid_q[l_idx][0] && (tag_q[l_idx][0] == l_tag);
    assign l_m1  = valid_q[l_idx][1] && (tag_q[l_idx][1] == l_tag);
    assign l_hit = !busy_q && (l_m0 || l_m1);
    assign l_ctr = l_m0 ? ctr_q[l_idx][0] : ctr_q[l_idx][1];

    assign bus.hit_o    = l_hit;
    assign bus.taken_o  = l_hit && l_ctr[1];
    assign bus.target_o = l_hit ? (l_m0 ? target_q[l_idx][0] : target_q[l_idx][1]) : 32'h0;
    assign bus.busy_o   = busy_q;

    // update path: decide which way to touch and its next counter value
    logic [INDEX_WIDTH-1:0] u_idx;
    logic [TW-1:0]          u_tag;
    logic                   u_go, u_m0, u_m1, u_hit;
    logic                   wr_way_d, wr_state_d, wr_data_d;
    logic [1:0]             ctr_cur, ctr_d;

    assign u_idx = bus.upd_pc_i[INDEX_WIDTH+1:2];
    assign u_tag = bus.upd_pc_i[31:INDEX_WIDTH+2];
    // a simultaneous flush request wins over the update
    assign u_go  = bus.upd_en_i && !busy_q && !bus.flush_i;
    assign u_m0  = valid_q[u_idx][0] && (tag_q[u_idx][0] == u_tag);
    assign u_m1  = valid_q[u_idx][1] && (tag_q[u_idx][1] == u_tag);
    assign u_hit = u_m0 || u_m1;

    // select victim/hit way and saturating counter update
    always_comb begin
        wr_way_d = 1'b0;
        ctr_cur  = 2'b00;
        ctr_d    = 2'b10;
        if (u_hit) begin
            wr_way_d = u_m0 ? 1'b0 : 1'b1;
            ctr_cur  = ctr_q[u_idx][wr_way_d];
            if (bus.upd_taken_i)
                ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
            else
                ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
        end else if (!valid_q[u_idx][0]) begin
            wr_way_d = 1'b0;
        end else if (!valid_q[u_idx][1]) begin
            wr_way_d = 1'b1;
        end else begin
            wr_way_d = lru_q[u_idx];
        end
        wr_state_d = u_go && (u_hit || bus.upd_taken_i);
        wr_data_d  = u_go && bus.upd_taken_i;
    end

    // flush sequencer: walks every set once, then returns to IDLE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush_i) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // valid, LRU and counter state: reset, flush clear, or update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]  <= 2'b00;
                ctr_q[s][0] <= 2'b01;
                ctr_q[s][1] <= 2'b01;
            end
            lru_q <= '0;
        end else if (busy_q) begin
            valid_q[cnt_q] <= 2'b00;
            lru_q[cnt_q]   <= 1'b0;
        end else if (wr_state_d) begin
            valid_q[u_idx][wr_way_d] <= 1'b1;
            ctr_q[u_idx][wr_way_d]   <= ctr_d;
            lru_q[u_idx]             <= ~wr_way_d;
        end
    end

    // tag/target payload: meaningless until the matching valid bit is set
    always_ff @(posedge clk_i) begin
        if (wr_data_d) begin
            tag_q[u_idx][wr_way_d]    <= u_tag;
            target_q[u_idx][wr_way_d] <= bus.upd_target_i;
        end
    end
endmodule

// File: tb/tb_btb_2way.sv
// Directed bench for btb_2way with INDEX_WIDTH=4 (0x100/0x140/0x180/0x1C0 share set 0,
// 0x13C lives in set 15, the last set the flush reaches).
module tb_btb_2way;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   nbusy;

    always #5 clk = ~clk;

    btb_2way_if bus ();

    btb_2way #(.INDEX_WIDTH(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.lookup_pc_i = pc;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.upd_en_i     = 1'b1;
        bus.upd_pc_i     = pc;
        bus.upd_taken_i  = tk;
        bus.upd_target_i = tgt;
        step();
        bus.upd_en_i     = 1'b0;
    endtask

    // counts busy cycles after flush has been accepted; optional drop-test update at cycle 3
    task automatic count_flush(input int hold, input bit inject, output int n);
        n = 0;
        for (int c = 0; c < 40 && bus.busy_o; c++) begin
            n++;
            look(32'h13C);
            chk("flush_miss_hit", {31'b0, bus.hit_o}, 32'h0);
            chk("flush_miss_tgt", bus.target_o, 32'h0);
            if (c >= hold) bus.flush_i = 1'b0;
            if (inject && c == 3) begin
                bus.upd_en_i     = 1'b1;
                bus.upd_pc_i     = 32'h1C0;
                bus.upd_taken_i  = 1'b1;
                bus.upd_target_i = 32'h2C0;
            end
            step();
            bus.upd_en_i = 1'b0;
        end
        bus.flush_i = 1'b0;
    endtask

    initial begin
        bus.lookup_pc_i  = 32'h0;
        bus.upd_en_i     = 1'b0;
        bus.upd_pc_i     = 32'h0;
        bus.upd_taken_i  = 1'b0;
        bus.upd_target_i = 32'h0;
        bus.flush_i      = 1'b0;

        // reset
        step(); step();
        look(32'h100);
        chk("rst_busy_during", {31'b0, bus.busy_o}, 32'h0);
        chk("rst_hit_during", {31'b0, bus.hit_o}, 32'h0);
        rst_n = 1'b1;
        step();
        look(32'h100);
        chk("rst_hit", {31'b0, bus.hit_o}, 32'h0);
        chk("rst_taken", {31'b0, bus.taken_o}, 32'h0);
        chk("rst_target", bus.target_o, 32'h0);
        chk("rst_busy", {31'b0, bus.busy_o}, 32'h0);

        // allocate; same-cycle lookup must still see the old (empty) entry
        bus.upd_en_i = 1'b1; bus.upd_pc_i = 32'h100; bus.upd_taken_i = 1'b1; bus.upd_target_i = 32'h200;
        look(32'h100);
        chk("same_cycle_old", {31'b0, bus.hit_o}, 32'h0);
        step();
        bus.upd_en_i = 1'b0;
        look(32'h100);
        chk("alloc_hit", {31'b0, bus.hit_o}, 32'h1);
        chk("alloc_taken", {31'b0, bus.taken_o}, 32'h1);
        chk("alloc_target", bus.target_o, 32'h200);

        // counter 10 -> 01 -> 00
        upd(32'h100, 1'b0, 32'h999);
        upd(32'h100, 1'b0, 32'h999);
        look(32'h100);
        chk("nt2_hit", {31'b0, bus.hit_o}, 32'h1);
        chk("nt2_taken", {31'b0, bus.taken_o}, 32'h0);
        chk("nt2_target", bus.target_o, 32'h200);
        // stays 00 (not wrapped to 11), then one taken gives 01 (still not taken)
        upd(32'h100, 1'b0, 32'h999);
        look(32'h100);
        chk("sat_low_taken", {31'b0, bus.taken_o}, 32'h0);
        upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        chk("sat_low_then_t", {31'b0, bus.taken_o}, 32'h0);

        // three tags in set 0: 0x100 evicted by LRU
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h140, 1'b1, 32'h240);
        upd(32'h180, 1'b1, 32'h280);
        look(32'h100);
        chk("evict_100_hit", {31'b0, bus.hit_o}, 32'h0);
        chk("evict_100_tgt", bus.target_o, 32'h0);
        look(32'h140);
        chk("keep_140_hit", {31'b0, bus.hit_o}, 32'h1);
        chk("keep_140_tgt", bus.target_o, 32'h240);
        look(32'h180);
        chk("keep_180_hit", {31'b0, bus.hit_o}, 32'h1);
        chk("keep_180_tgt", bus.target_o, 32'h280);
        chk("keep_180_taken", {31'b0, bus.taken_o}, 32'h1);

        // not-taken miss changes nothing
        upd(32'h1C0, 1'b0, 32'h2C0);
        look(32'h1C0);
        chk("nt_miss_1c0", {31'b0, bus.hit_o}, 32'h0);
        look(32'h140);
        chk("nt_miss_140", bus.target_o, 32'h240);
        look(32'h180);
        chk("nt_miss_180", bus.target_o, 32'h280);

        // flush with an entry in the last set, update injected mid-flush
        upd(32'h13C, 1'b1, 32'h33C);
        look(32'h13C);
        chk("set15_hit", bus.target_o, 32'h33C);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_busy_start", {31'b0, bus.busy_o}, 32'h1);
        count_flush(0, 1'b1, nbusy);
        chk("flush_len", nbusy, 32'd16);
        look(32'h140);
        chk("post_flush_140", {31'b0, bus.hit_o}, 32'h0);
        look(32'h180);
        chk("post_flush_180", {31'b0, bus.hit_o}, 32'h0);
        look(32'h13C);
        chk("post_flush_13c", {31'b0, bus.hit_o}, 32'h0);
        look(32'h1C0);
        chk("flush_upd_drop", {31'b0, bus.hit_o}, 32'h0);

        // flush and update together: flush wins
        bus.flush_i = 1'b1;
        bus.upd_en_i = 1'b1; bus.upd_pc_i = 32'h100; bus.upd_taken_i = 1'b1; bus.upd_target_i = 32'h200;
        step();
        bus.flush_i = 1'b0;
        bus.upd_en_i = 1'b0;
        count_flush(0, 1'b0, nbusy);
        chk("prio_flush_len", nbusy, 32'd16);
        look(32'h100);
        chk("prio_upd_drop", {31'b0, bus.hit_o}, 32'h0);

        // reset in the middle of a flush
        upd(32'h140, 1'b1, 32'h240);
        upd(32'h13C, 1'b1, 32'h33C);
        look(32'h140);
        chk("refill_140", bus.target_o, 32'h240);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("midflush_busy", {31'b0, bus.busy_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, bus.busy_o}, 32'h0);
        look(32'h140);
        chk("rst_mid_hit", {31'b0, bus.hit_o}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", {31'b0, bus.busy_o}, 32'h0);
        look(32'h140);
        chk("post_rst_140", {31'b0, bus.hit_o}, 32'h0);
        look(32'h13C);
        chk("post_rst_13c", {31'b0, bus.hit_o}, 32'h0);

        // flush_i held high during FLUSH must not restart it
        bus.flush_i = 1'b1;
        step();
        count_flush(2, 1'b0, nbusy);
        chk("no_restart_len", nbusy, 32'd16);
        chk("idle_after", {31'b0, bus.busy_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/btb_2way.md
BTB_2WAY -- requirements
Module: btb_2way

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6: set-index width; sets = 2**INDEX_WIDTH; tag width TW = 32-INDEX_WIDTH-2.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port lookup_pc_i  input  32  fetch PC to predict.
REQ-005 SHALL have port hit_o  output  1  valid tag match for lookup_pc_i.
REQ-006 SHALL have port taken_o  output  1  predict taken: hit_o and MSB of matching counter.
REQ-007 SHALL have port target_o  output  32  target of matching way; 0 when hit_o=0.
REQ-008 SHALL have port upd_en_i  input  1  resolved-branch update strobe.
REQ-009 SHALL have port upd_pc_i  input  32  PC of resolved branch.
REQ-010 SHALL have port upd_taken_i  input  1  resolved direction.
REQ-011 SHALL have port upd_target_i  input  32  resolved target.
REQ-012 SHALL have port flush_i  input  1  request to invalidate all entries.
REQ-013 SHALL have port busy_o  output  1  flush in progress.

Function
REQ-014 SHALL organise storage as 2 ways per set; per entry: valid, TW-bit tag, 32-bit target, 2-bit saturating counter; per set: 1 LRU bit naming the way to replace next.
REQ-015 SHALL derive index = pc[INDEX_WIDTH+1:2], tag = pc[31:INDEX_WIDTH+2] for both lookup and update.
REQ-016 SHALL produce the lookup combinationally from current state; lookup SHALL NOT modify any state, LRU included.
REQ-017 SHALL force hit_o=0, taken_o=0, target_o=0 while busy_o=1.
REQ-018 SHALL, on update hit (valid matching way, busy_o=0): taken increments counter saturating at 2'b11, not-taken decrements saturating at 2'b00; target written only when upd_taken_i=1; LRU set to the other way.
REQ-019 SHALL, on update miss with upd_taken_i=1: allocate way0 if invalid, else way1 if invalid, else the LRU way; write valid=1, tag, target, counter=2'b10; LRU set to the other way.
REQ-020 SHALL, on update miss with upd_taken_i=0, change no state.
REQ-021 SHALL make updates visible to lookup from the cycle after the update edge; a same-cycle lookup of the updated entry sees the old contents.
REQ-022 SHALL implement FSM IDLE/FLUSH: IDLE with flush_i=1 -> FLUSH, set counter = 0; in FLUSH clear valid and LRU of set[counter] each cycle, counter+1; after clearing set 2**INDEX_WIDTH-1 -> IDLE.
REQ-023 SHALL assert busy_o in FLUSH only; a flush therefore takes exactly 2**INDEX_WIDTH cycles of busy_o=1.
REQ-024 SHALL ignore flush_i while in FLUSH (no restart) and SHALL drop upd_en_i while busy_o=1.
REQ-025 SHALL give flush priority when flush_i and upd_en_i are both 1 in IDLE: the update is dropped.
REQ-026 SHALL never have two valid ways in one set holding the same tag.

Reset
REQ-027 SHALL, on rst_ni=0, immediately clear every valid bit, every LRU bit and every counter to 2'b01, and set FSM to IDLE with flush counter 0; tags/targets need no reset.
REQ-028 SHALL hold outputs at hit_o=0, taken_o=0, target_o=0, busy_o=0 during and directly after reset, including reset asserted mid-flush.

Verification (INDEX_WIDTH=4; 0x100, 0x140, 0x180 all map to set 0)
REQ-029 SHALL cover: reset, lookup 0x100 -> hit_o=0, taken_o=0, target_o=0, busy_o=0.
REQ-030 SHALL cover: update 0x100 taken target 0x200, then lookup 0x100 -> hit_o=1, taken_o=1, target_o=0x200; then two not-taken updates -> hit_o=1, taken_o=0, target_o=0x200; then one not-taken update more -> counter stays 2'b00.
REQ-031 SHALL cover: taken updates 0x100->0x200, 0x140->0x240, 0x180->0x280 in successive cycles -> 0x100 misses; 0x140 hits 0x240; 0x180 hits 0x280.
REQ-032 SHALL cover: not-taken update of absent 0x1C0 -> lookup 0x1C0 misses and existing set-0 entries are unchanged.
REQ-033 SHALL cover: fill entries, pulse flush_i one cycle -> busy_o=1 for exactly 16 cycles, lookups miss throughout; an upd_en_i during the flush is dropped; all lookups miss after busy_o falls.
REQ-034 SHALL cover: flush_i and upd_en_i (0x100 taken) together in IDLE -> flush runs, 0x100 misses afterwards; rst_ni low at flush cycle 5 -> busy_o=0 at once, all entries miss.
